seg_scan: RTL

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan
// Function : Four-digit multiplexed 7-segment scanner with blank phases between
//            digits, frame-synchronous snapshot and leading-zero blanking.
// Revision : 1.0  initial release
// ============================================================================
module seg_scan #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_div,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    localparam logic [3:0] C_AN_OFF  = ACTIVE_LOW ? 4'hF  : 4'h0;
    localparam logic [6:0] C_SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       C_DP_OFF  = ACTIVE_LOW ? 1'b1  : 1'b0;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        clk_div_q;
    logic        tick;
    logic [15:0] snap_digits_q, snap_digits_d;
    logic [3:0]  snap_dp_q, snap_dp_d;
    logic        snap_lz_q, snap_lz_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic        frame_done_q, frame_done_d;

    logic [3:0]  nibble;
    logic [3:0]  lz_blank;
    logic [6:0]  seg_dec;
    logic [3:0]  an_low;
    logic [6:0]  seg_low;
    logic        dp_low;

    always_comb begin
        tick          = clk_div & ~clk_div_q;
        state_d       = state_q;
        idx_d         = idx_q;
        snap_digits_d = snap_digits_q;
        snap_dp_d     = snap_dp_q;
        snap_lz_d     = snap_lz_q;
        frame_done_d  = 1'b0;
        if (tick) begin
            case (state_q)
                ST_BLANK: begin
                    state_d = ST_DRIVE;
                    // Latch new data only at the start of a frame to avoid tearing
                    if (idx_q == 2'd0) begin
                        snap_digits_d = digits;
                        snap_dp_d     = dp_in;
                        snap_lz_d     = blank_lz;
                    end
                end
                ST_DRIVE: begin
                    state_d      = ST_BLANK;
                    idx_d        = idx_q + 2'd1;
                    frame_done_d = (idx_q == 2'd3);
                end
                default: state_d = ST_BLANK;
            endcase
        end
    end

    // Outputs are derived from next-state values so they are registered on the tick edge
    always_comb begin
        case (idx_d)
            2'd0:    nibble = snap_digits_d[3:0];
            2'd1:    nibble = snap_digits_d[7:4];
            2'd2:    nibble = snap_digits_d[11:8];
            default: nibble = snap_digits_d[15:12];
        endcase

        lz_blank[3] = snap_lz_d && (snap_digits_d[15:12] == 4'h0);
        lz_blank[2] = lz_blank[3] && (snap_digits_d[11:8] == 4'h0);
        lz_blank[1] = lz_blank[2] && (snap_digits_d[7:4] == 4'h0);
        lz_blank[0] = 1'b0;

        case (nibble)
            4'h0:    seg_dec = 7'h40;
            4'h1:    seg_dec = 7'h79;
            4'h2:    seg_dec = 7'h24;
            4'h3:    seg_dec = 7'h30;
            4'h4:    seg_dec = 7'h19;
            4'h5:    seg_dec = 7'h12;
            4'h6:    seg_dec = 7'h02;
            4'h7:    seg_dec = 7'h78;
            4'h8:    seg_dec = 7'h00;
            4'h9:    seg_dec = 7'h10;
            4'hA:    seg_dec = 7'h08;
            4'hB:    seg_dec = 7'h03;
            4'hC:    seg_dec = 7'h46;
            4'hD:    seg_dec = 7'h21;
            4'hE:    seg_dec = 7'h06;
            default: seg_dec = 7'h0E;
        endcase

        an_low  = 4'hF;
        seg_low = 7'h7F;
        dp_low  = 1'b1;
        if ((state_d == ST_DRIVE) && !lz_blank[idx_d]) begin
            an_low[idx_d] = 1'b0;
            seg_low       = seg_dec;
            dp_low        = ~snap_dp_d[idx_d];
        end

        an_d  = ACTIVE_LOW ? an_low  : ~an_low;
        seg_d = ACTIVE_LOW ? seg_low : ~seg_low;
        dp_d  = ACTIVE_LOW ? dp_low  : ~dp_low;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_div_q     <= 1'b0;
            state_q       <= ST_BLANK;
            idx_q         <= 2'd0;
            snap_digits_q <= 16'h0000;
            snap_dp_q     <= 4'h0;
            snap_lz_q     <= 1'b0;
            an_q          <= C_AN_OFF;
            seg_q         <= C_SEG_OFF;
            dp_q          <= C_DP_OFF;
            frame_done_q  <= 1'b0;
        end else begin
            clk_div_q     <= clk_div;
            state_q       <= state_d;
            idx_q         <= idx_d;
            snap_digits_q <= snap_digits_d;
            snap_dp_q     <= snap_dp_d;
            snap_lz_q     <= snap_lz_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire
